// File: rtl/risc_16_bit.sv
// risc_16_bit: single-cycle 16-bit RISC core with an internal instruction ROM,
// an 8x16 register file and an 8x16 data memory. Every datapath and control
// signal is brought out as a debug tap so the core can be observed cycle by cycle.
module risc_16_bit (
    input  logic         clk,
    input  logic         rst,
    output logic [15:0]  pc_current,
    output logic [15:0]  pc_next,
    output logic [15:0]  pc2,
    output logic [15:0]  PC_j,
    output logic [15:0]  PC_beq,
    output logic [15:0]  PC_2beq,
    output logic [15:0]  PC_bne,
    output logic [15:0]  PC_2bne,
    output logic [15:0]  instr,
    output logic [3:0]   opcode,
    output logic [12:0]  jump_shift,
    output logic [1:0]   reg_dst,
    output logic [1:0]   mem_to_reg,
    output logic [1:0]   alu_op,
    output logic         jump,
    output logic         beq,
    output logic         bne,
    output logic         mem_read,
    output logic         mem_write,
    output logic         alu_src,
    output logic         reg_write,
    output logic         beq_control,
    output logic         bne_control,
    output logic         zero_flag,
    output logic [2:0]   reg_read_addr_1,
    output logic [2:0]   reg_read_addr_2,
    output logic [2:0]   reg_write_dest,
    output logic [15:0]  reg_read_data_1,
    output logic [15:0]  reg_read_data_2,
    output logic [15:0]  reg_write_data,
    output logic [15:0]  alu_in1,
    output logic [15:0]  alu_in2,
    output logic [15:0]  ALU_out,
    output logic [2:0]   ALU_Control,
    output logic [15:0]  mem_access_addr,
    output logic [15:0]  mem_write_data,
    output logic [15:0]  mem_read_data,
    output logic [127:0] reg_array,
    output logic [127:0] memory
);

    typedef enum logic [3:0] {
        OP_LD  = 4'h0,
        OP_ST  = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_INV = 4'h4,
        OP_LSL = 4'h5,
        OP_LSR = 4'h6,
        OP_AND = 4'h7,
        OP_OR  = 4'h8,
        OP_SLT = 4'h9,
        OP_BEQ = 4'hB,
        OP_BNE = 4'hC,
        OP_JMP = 4'hD
    } opcode_e;

    logic [15:0] regs [8];
    logic [15:0] dmem [8];
    logic [15:0] imm;

    // Instruction ROM: fixed program, one halfword per even PC value.
    always_comb begin
        case (pc_current[4:1])
            4'd0:    instr = 16'h0400;
            4'd1:    instr = 16'h0441;
            4'd2:    instr = 16'h2050;
            4'd3:    instr = 16'h1280;
            4'd4:    instr = 16'h3050;
            4'd5:    instr = 16'h4050;
            4'd6:    instr = 16'h5050;
            4'd7:    instr = 16'h6050;
            4'd8:    instr = 16'h7050;
            4'd9:    instr = 16'h8050;
            4'd10:   instr = 16'h9050;
            4'd11:   instr = 16'h2000;
            4'd12:   instr = 16'hB041;
            4'd13:   instr = 16'hC040;
            4'd14:   instr = 16'hD000;
            default: instr = 16'h0000;
        endcase
    end

    assign opcode          = instr[15:12];
    assign jump_shift      = {instr[11:0], 1'b0};
    assign reg_read_addr_1 = instr[11:9];
    assign reg_read_addr_2 = instr[8:6];
    assign imm             = {{10{instr[5]}}, instr[5:0]};

    // Main decoder: every control tap starts at zero so unlisted opcodes act as NOPs.
    // NOTE: assigning a default to every output before the case keeps always_comb free of latches.
    always_comb begin
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_op     = 2'b00;
        jump       = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        case (opcode)
            OP_LD: begin
                alu_op     = 2'b10;
                mem_to_reg = 2'b01;
                mem_read   = 1'b1;
                alu_src    = 1'b1;
                reg_write  = 1'b1;
            end
            OP_ST: begin
                alu_op    = 2'b10;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_SLT: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
            end
            OP_BEQ: begin
                alu_op = 2'b01;
                beq    = 1'b1;
            end
            OP_BNE: begin
                alu_op = 2'b01;
                bne    = 1'b1;
            end
            OP_JMP: jump = 1'b1;
            default: ;
        endcase
    end

    // ALU function select; R-type opcodes 2..9 map directly onto codes 0..7.
    always_comb begin
        case (alu_op)
            2'b10:   ALU_Control = 3'b000;
            2'b01:   ALU_Control = 3'b001;
            default: ALU_Control = opcode[2:0] - 3'd2;
        endcase
    end

    assign reg_read_data_1 = regs[reg_read_addr_1];
    assign reg_read_data_2 = regs[reg_read_addr_2];
    assign alu_in1         = reg_read_data_1;
    assign alu_in2         = alu_src ? imm : reg_read_data_2;

    // ALU datapath; shifts use the full 16-bit amount, so 16 or more yields zero.
    always_comb begin
        case (ALU_Control)
            3'b000:  ALU_out = alu_in1 + alu_in2;
            3'b001:  ALU_out = alu_in1 - alu_in2;
            3'b010:  ALU_out = ~alu_in1;
            3'b011:  ALU_out = alu_in1 << alu_in2;
            3'b100:  ALU_out = alu_in1 >> alu_in2;
            3'b101:  ALU_out = alu_in1 & alu_in2;
            3'b110:  ALU_out = alu_in1 | alu_in2;
            default: ALU_out = (alu_in1 < alu_in2) ? 16'd1 : 16'd0;
        endcase
    end

    assign zero_flag       = (ALU_out == 16'd0);
    assign mem_access_addr = ALU_out;
    assign mem_write_data  = reg_read_data_2;
    assign mem_read_data   = mem_read ? dmem[ALU_out[2:0]] : 16'd0;
    assign reg_write_dest  = reg_dst[0] ? instr[5:3] : reg_read_addr_2;
    assign reg_write_data  = mem_to_reg[0] ? mem_read_data : ALU_out;

    assign pc2         = pc_current + 16'd2;
    assign PC_beq      = pc2 + (imm << 1);
    assign PC_bne      = PC_beq;
    assign beq_control = beq & zero_flag;
    assign bne_control = bne & ~zero_flag;
    assign PC_2beq     = beq_control ? PC_beq : pc2;
    assign PC_2bne     = bne_control ? PC_bne : PC_2beq;
    assign PC_j        = {pc2[15:13], jump_shift};
    assign pc_next     = jump ? PC_j : PC_2bne;

    // Program counter advances to the selected next PC every cycle.
    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) pc_current <= 16'd0;
        else     pc_current <= pc_next;
    end

    // Register file write port; reads above see the pre-edge contents.
    // NOTE: this array is cleared on reset because software relies on all registers starting at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else if (reg_write) begin
            regs[reg_write_dest] <= reg_write_data;
        end
    end

    // Data memory write port; reset loads the two seed operands into words 0 and 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 2; i < 8; i++) dmem[i] <= 16'd0;
            dmem[0] <= 16'h0001;
            dmem[1] <= 16'h0002;
        end else if (mem_write) begin
            dmem[ALU_out[2:0]] <= mem_write_data;
        end
    end

    // Flatten register file and data memory for the packed debug taps.
    always_comb begin
        reg_array = '0;
        memory    = '0;
        for (int i = 0; i < 8; i++) begin
            reg_array[i*16 +: 16] = regs[i];
            memory[i*16 +: 16]    = dmem[i];
        end
    end

endmodule

// File: tb/tb_risc_16_bit.sv
// tb_risc_16_bit: directed run of the built-in program with hand-computed
// expectations for registers, memory, PC path and decoder taps, plus a
// mid-program reset.
module tb_risc_16_bit;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  pc_current, pc_next, pc2, PC_j, PC_beq, PC_2beq, PC_bne, PC_2bne;
    logic [15:0]  instr;
    logic [3:0]   opcode;
    logic [12:0]  jump_shift;
    logic [1:0]   reg_dst, mem_to_reg, alu_op;
    logic         jump, beq, bne, mem_read, mem_write, alu_src, reg_write;
    logic         beq_control, bne_control, zero_flag;
    logic [2:0]   reg_read_addr_1, reg_read_addr_2, reg_write_dest;
    logic [15:0]  reg_read_data_1, reg_read_data_2, reg_write_data;
    logic [15:0]  alu_in1, alu_in2, ALU_out;
    logic [2:0]   ALU_Control;
    logic [15:0]  mem_access_addr, mem_write_data, mem_read_data;
    logic [127:0] reg_array, memory;

    int n_cmp = 0;
    int n_bad = 0;

    risc_16_bit dut (
        .clk(clk), .rst(rst),
        .pc_current(pc_current), .pc_next(pc_next), .pc2(pc2), .PC_j(PC_j),
        .PC_beq(PC_beq), .PC_2beq(PC_2beq), .PC_bne(PC_bne), .PC_2bne(PC_2bne),
        .instr(instr), .opcode(opcode), .jump_shift(jump_shift),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .beq_control(beq_control),
        .bne_control(bne_control), .zero_flag(zero_flag),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .reg_write_dest(reg_write_dest), .reg_read_data_1(reg_read_data_1),
        .reg_read_data_2(reg_read_data_2), .reg_write_data(reg_write_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ALU_out(ALU_out), .ALU_Control(ALU_Control),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .reg_array(reg_array), .memory(memory)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word(input logic [127:0] vec, input int idx);
        return vec[idx*16 +: 16];
    endfunction

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // R2 after edges 5..11: SUB, INV, LSL, LSR, AND, OR, SLT of R0=1, R1=2.
    logic [15:0] r2_seq [7] = '{16'hFFFF, 16'hFFFE, 16'h0004, 16'h0000,
                                16'h0000, 16'h0003, 16'h0001};

    initial begin
        rst = 1'b1;
        step();
        check("rst_pc", pc_current, 16'h0000);
        check("rst_regs_lo", word(reg_array, 0) | word(reg_array, 1) | word(reg_array, 2), 16'h0000);
        check("rst_mem0", word(memory, 0), 16'h0001);
        check("rst_mem1", word(memory, 1), 16'h0002);
        check("rst_mem2", word(memory, 2), 16'h0000);
        check("rst_instr", instr, 16'h0400);
        check("ld_alu_op", {14'd0, alu_op}, 16'd2);
        check("ld_ctrl", {12'd0, mem_read, alu_src, mem_to_reg[0], reg_write}, 16'hF);

        rst = 1'b0;
        step();
        check("e1_r0", word(reg_array, 0), 16'h0001);
        step();
        check("e2_r1", word(reg_array, 1), 16'h0002);
        step();
        check("e3_r2", word(reg_array, 2), 16'h0003);
        check("st_mem_write", {15'd0, mem_write}, 16'd1);
        check("st_reg_write", {15'd0, reg_write}, 16'd0);
        check("st_addr", mem_access_addr, 16'h0002);
        check("st_wdata", mem_write_data, 16'h0003);
        step();
        check("e4_r2", word(reg_array, 2), 16'h0003);
        check("e4_mem2", word(memory, 2), 16'h0003);
        check("sub_ctrl", {13'd0, ALU_Control}, 16'd1);
        check("sub_out", ALU_out, 16'hFFFF);

        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("e%0d_r2", k + 5), word(reg_array, 2), r2_seq[k]);
        end
        check("add_dest", {13'd0, reg_write_dest}, 16'd0);
        check("add_reg_dst", {14'd0, reg_dst}, 16'd1);

        step();
        check("e12_r0", word(reg_array, 0), 16'h0002);
        check("beq_zero", {15'd0, zero_flag}, 16'd1);
        check("beq_control", {15'd0, beq_control}, 16'd1);
        check("beq_alu_op", {14'd0, alu_op}, 16'd1);
        check("beq_target", PC_2beq, 16'h001C);
        check("beq_pc_next", pc_next, 16'h001C);

        step();
        check("e13_pc", pc_current, 16'h001C);
        check("jmp_instr", instr, 16'hD000);
        check("jmp_flag", {15'd0, jump}, 16'd1);
        check("jmp_target", PC_j, 16'h0000);

        step();
        check("e14_pc", pc_current, 16'h0000);
        step();
        check("e15_r0", word(reg_array, 0), 16'h0002);
        step();
        check("e16_r1", word(reg_array, 1), 16'h0003);

        // Run to PC 0x0010, then reset in the middle of the program.
        for (int i = 0; i < 40 && pc_current != 16'h0010; i++) step();
        check("reach_pc10", pc_current, 16'h0010);
        rst = 1'b1;
        step();
        check("mid_rst_pc", pc_current, 16'h0000);
        check("mid_rst_r0", word(reg_array, 0), 16'h0000);
        check("mid_rst_r1", word(reg_array, 1), 16'h0000);
        check("mid_rst_r2", word(reg_array, 2), 16'h0000);
        check("mid_rst_mem0", word(memory, 0), 16'h0001);
        check("mid_rst_mem1", word(memory, 1), 16'h0002);
        check("mid_rst_mem2", word(memory, 2), 16'h0000);
        rst = 1'b0;
        step();
        check("restart_pc", pc_current, 16'h0002);
        check("restart_r0", word(reg_array, 0), 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/risc_16_bit.md
RISC_16_BIT -- requirements
Module: risc_16_bit

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 pc_current, pc_next, pc2, PC_j, PC_beq, PC_2beq, PC_bne, PC_2bne  out  16 each  PC-path debug taps.
REQ-004 instr  out  16  fetched instruction; opcode  out  4  = instr[15:12]; jump_shift  out  13  = {instr[11:0],1'b0}.
REQ-005 reg_dst, mem_to_reg, alu_op  out  2 each; jump, beq, bne, mem_read, mem_write, alu_src, reg_write, beq_control, bne_control, zero_flag  out  1 each  control taps.
REQ-006 reg_read_addr_1, reg_read_addr_2, reg_write_dest  out  3 each; reg_read_data_1, reg_read_data_2, reg_write_data  out  16 each.
REQ-007 alu_in1, alu_in2, ALU_out  out  16 each; ALU_Control  out  3.
REQ-008 mem_access_addr, mem_write_data, mem_read_data  out  16 each.
REQ-009 reg_array  out  128  R7..R0 packed, R0 in [15:0]; memory  out  128  data words 7..0 packed, word 0 in [15:0].

Function
REQ-010 Single-cycle: one instruction fetched, executed and committed per clk edge.
REQ-011 Instruction ROM: 16 words indexed pc_current[4:1]; words 0-14 = 0400,0441,2050,1280,3050,4050,5050,6050,7050,8050,9050,2000,B041,C040,D000; word 15 = 0000.
REQ-012 Fields: rs1=[11:9], rs2=[8:6], rd=[5:3]; imm6=[5:0] sign-extended to 16; reg_read_addr_1=rs1, reg_read_addr_2=rs2.
REQ-013 Opcodes: 0 LD rs2<-mem[rs1+imm]; 1 ST mem[rs1+imm]<-rs2; 2 ADD; 3 SUB; 4 INV(~rs1); 5 LSL; 6 LSR; 7 AND; 8 OR; 9 SLT; B BEQ; C BNE; D JMP; A,E,F = NOP (all controls 0).
REQ-014 alu_op: 10 for LD/ST, 01 for BEQ/BNE, 00 for R-type (2-9); reg_dst=1 only for R-type; mem_to_reg=1, mem_read=1 only for LD; alu_src=1 for LD/ST; reg_write=1 for LD and R-type; mem_write=1 for ST.
REQ-015 ALU_Control: alu_op 10 -> 000; 01 -> 001; 00 -> opcode-2 (ADD 000 ... SLT 111).
REQ-016 ALU: 000 a+b, 001 a-b, 010 ~a, 011 a<<b, 100 a>>b (logical), 101 a&b, 110 a|b, 111 (a<b unsigned)?1:0; add/sub wrap mod 2^16; shift amount = full b, >=16 gives 0.
REQ-017 alu_in1=reg_read_data_1; alu_in2 = alu_src ? imm : reg_read_data_2; zero_flag = (ALU_out==0).
REQ-018 reg_write_dest = reg_dst ? rd : rs2; reg_write_data = mem_to_reg ? mem_read_data : ALU_out.
REQ-019 Register file 8x16, combinational read, write on edge when reg_write; R0 is writable.
REQ-020 Data memory 8x16, address ALU_out[2:0] (mem_access_addr=ALU_out, upper bits ignored); combinational read (0 when mem_read=0); write on edge when mem_write; mem_write_data=reg_read_data_2.
REQ-021 pc2=pc_current+2; PC_beq=pc2+(imm<<1); beq_control=beq&zero_flag; PC_2beq=beq_control?PC_beq:pc2; PC_bne=PC_beq; bne_control=bne&~zero_flag; PC_2bne=bne_control?PC_bne:PC_2beq.
REQ-022 PC_j={pc2[15:13],jump_shift}; pc_next=jump?PC_j:PC_2bne; pc_current<=pc_next each edge.
REQ-023 Same-cycle read-after-write: reads return pre-edge values.

Reset
REQ-024 rst=1 at edge: pc_current=0, all registers 0, data memory = {word0=0001, word1=0002, others 0000}; no write enables honored during reset.
REQ-025 rst mid-program discards in-flight instruction; execution restarts at pc 0 on first edge after release.

Verification
REQ-026 Reset, release, 2 edges -> R0=0001, R1=0002.
REQ-027 After 4 edges -> R2=0003, memory word2=0003.
REQ-028 After edges 5..11 -> R2 sequence FFFF, FFFE, 0004, 0000, 0000, 0003, 0001.
REQ-029 Edge 12 -> R0=0002; edge 13 (BEQ taken, R0==R1) -> pc_current=001C, BNE skipped.
REQ-030 Edge 14 (JMP) -> pc_current=0000; next LD gives R0=mem[1]=0002, then R1=mem[2]=0003.
REQ-031 Assert rst during pc 0010 -> next state pc=0, regs 0, memory reinitialized.
